// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the multi-channel clock divider
package clk_div_pkg;

  localparam int CNT_W_DEF = 8;

  // Phase at which every period starts and div_tick fires.
  localparam int PHASE_START = 0;

  // Channel index width, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: phase counter, active/pending divisors, registered outputs
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int RST_DIV = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             sync,
  output logic             pend,
  output logic             div_out,
  output logic             div_tick,
  output logic             active
);

  localparam logic [CNT_W-1:0] RST_D  = CNT_W'(RST_DIV);
  localparam logic             RST_ON = (RST_DIV != 0);
  localparam logic [CNT_W-1:0] PH0    = CNT_W'(PHASE_START);

  logic [CNT_W-1:0] act_div, pend_div, cnt;
  logic [CNT_W-1:0] nxt_div, nxt_cnt;
  logic [CNT_W:0]   nxt_half;
  logic             running, wrap, apply;

  // Outputs are registered from the next-state values so they show the phase cnt will hold.
  always_comb begin
    running  = (act_div != '0);
    wrap     = running && (cnt == act_div - 1'b1);
    apply    = pend && (!running || wrap || sync);
    nxt_div  = apply ? pend_div : act_div;
    if (nxt_div == '0)
      nxt_cnt = PH0;
    else if (wrap || apply || (sync && running))
      nxt_cnt = PH0;
    else
      nxt_cnt = cnt + 1'b1;
    nxt_half = ({1'b0, nxt_div} + 1'b1) >> 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_div  <= RST_D;
      pend_div <= '0;
      pend     <= 1'b0;
      cnt      <= PH0;
      div_out  <= RST_ON;
      div_tick <= RST_ON;
      active   <= RST_ON;
    end else begin
      act_div  <= nxt_div;
      cnt      <= nxt_cnt;
      if (wr) begin
        pend     <= 1'b1;
        pend_div <= wr_div;
      end else if (apply) begin
        pend <= 1'b0;
      end
      div_tick <= (nxt_div != '0) && (nxt_cnt == PH0);
      div_out  <= (nxt_div != '0) && ({1'b0, nxt_cnt} < nxt_half);
      active   <= (nxt_div != '0);
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable divider top: cfg decode, ready mux, sync fan-out
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int RST_DIV = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [ch_w(NUM_CH)-1:0]    cfg_ch,
  input  logic [CNT_W-1:0]           cfg_div,
  input  logic                       sync,
  output logic [NUM_CH-1:0]          div_out,
  output logic [NUM_CH-1:0]          div_tick,
  output logic [NUM_CH-1:0]          ch_active
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] pend;

  // Out-of-range indices keep the default ready and match no channel, so the write is dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pend[i];
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr;
    assign wr = cfg_valid && (cfg_ch == CH_W'(g)) && !pend[g];

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .RST_DIV (RST_DIV)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr),
      .wr_div   (cfg_div),
      .sync     (sync),
      .pend     (pend[g]),
      .div_out  (div_out[g]),
      .div_tick (div_tick[g]),
      .active   (ch_active[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - self-checking bench for clk_div_multi against a phase/period reference model
module tb_clk_div_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [1:0]        cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic              sync = 1'b0;
  logic [NUM_CH-1:0] div_out, div_tick, ch_active;

  int n_asrt = 0;
  int n_fail = 0;

  // Reference: per channel the divisor in force, the phase shown, and any queued divisor.
  int m_d   [NUM_CH];
  int m_ph  [NUM_CH];
  int m_pd  [NUM_CH];
  bit m_pend[NUM_CH];

  clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RST_DIV(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .sync      (sync),
    .div_out   (div_out),
    .div_tick  (div_tick),
    .ch_active (ch_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_d[c] = 0; m_ph[c] = 0; m_pd[c] = 0; m_pend[c] = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NUM_CH-1:0] eo, et, ea;
    for (int c = 0; c < NUM_CH; c++) begin
      ea[c] = (m_d[c] > 0);
      et[c] = (m_d[c] > 0) && (m_ph[c] == 0);
      eo[c] = (m_d[c] > 0) && (m_ph[c] < (m_d[c] + 1) / 2);
    end
    chk({tag, ".div_out"},   32'(div_out),   32'(eo));
    chk({tag, ".div_tick"},  32'(div_tick),  32'(et));
    chk({tag, ".ch_active"}, 32'(ch_active), 32'(ea));
  endtask

  // Called at a negedge with inputs set; advances one clock and checks at the next negedge.
  task automatic step(input string tag);
    bit acc;
    bit ends;
    chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(!m_pend[cfg_ch]));
    acc = cfg_valid && !m_pend[cfg_ch];
    @(posedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      ends = (m_d[c] > 0) && (m_ph[c] == m_d[c] - 1);
      if (m_pend[c] && (m_d[c] == 0 || ends || sync)) begin
        m_d[c] = m_pd[c]; m_ph[c] = 0; m_pend[c] = 0;
      end else if (m_d[c] > 0) begin
        m_ph[c] = sync ? 0 : (m_ph[c] + 1) % m_d[c];
      end
      if (acc && cfg_ch == 2'(c)) begin
        m_pend[c] = 1; m_pd[c] = int'(cfg_div);
      end
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    cfg_valid = 1'b0; sync = 1'b0;
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic cfg_write(input string tag, input int ch, input int d);
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_div = CNT_W'(d);
    step(tag);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("rst");
    chk("rst.cfg_ready", 32'(cfg_ready), 32'd1);
    reset = 1'b0;
    idle("post_rst", 2);

    cfg_write("ch0_d4_acc", 0, 4);
    step("ch0_d4_apply");
    chk("ch0_first_tick", 32'(div_tick[0]), 32'd1);
    idle("ch0_d4", 12);

    cfg_write("ch1_d5", 1, 5);
    idle("ch1_d5_run", 11);
    cfg_write("ch1_d1", 1, 1);
    idle("ch1_d1_run", 8);

    cfg_write("ch0_d6", 0, 6);
    guard = 0;
    while (!(m_d[0] == 6 && m_ph[0] == 1 && !m_pend[0]) && guard < 30) begin
      step("ch0_wait_ph1"); guard++;
    end
    chk("ch0_reach_ph1", 32'(guard < 30), 32'd1);
    cfg_write("ch0_d2", 0, 2);
    cfg_ch = 2'd1; #1;
    chk("rdy_other_ch", 32'(cfg_ready), 32'd1);
    cfg_ch = 2'd0; #1;
    chk("rdy_held_ch0", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b1; cfg_div = 8'd3;
    guard = 0;
    while (m_pend[0] && guard < 30) begin
      step("ch0_holdoff"); guard++;
    end
    step("ch0_second_acc");
    cfg_valid = 1'b0;
    chk("holdoff_bounded", 32'(guard < 30), 32'd1);
    idle("ch0_d2_then_d3", 12);

    cfg_write("ch2_d7", 2, 7);
    idle("ch2_run", 4 + int'($urandom_range(0, 6)));
    sync = 1'b1;
    step("sync");
    sync = 1'b0;
    chk("sync_ticks", 32'(div_tick[0] && div_tick[2]), 32'd1);
    idle("post_sync", 14);

    cfg_write("ch3_d8", 3, 8);
    guard = 0;
    while (!(m_d[3] == 8 && m_ph[3] == 1) && guard < 30) begin
      step("ch3_wait"); guard++;
    end
    chk("ch3_reach_ph", 32'(guard < 30), 32'd1);
    cfg_write("ch3_d0", 3, 0);
    idle("ch3_finish", 8);
    chk("ch3_off", 32'(ch_active[3]), 32'd0);

    for (int i = 0; i < 400; i++) begin
      sync      = ($urandom_range(0, 19) == 0);
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: cfg_div = CNT_W'($urandom_range(0, 3));
        1: cfg_div = CNT_W'($urandom_range(0, 20));
        2: cfg_div = CNT_W'($urandom_range(0, 255));
        default: cfg_div = CNT_W'($urandom_range(2, 9));
      endcase
      step("rand");
    end
    idle("rand_drain", 3);

    cfg_write("pre_rst_wr", 0, 5);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    chk("async_rst.cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    idle("after_rst", 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
